// File: rtl/seq_mod_reduce_q_pkg.sv
// Shared constants for the p25519 field arithmetic blocks: element and product
// widths, the prime q = 2^255 - 19, and the reducer's state encoding.
package seq_mod_reduce_q_pkg;

    localparam int FE_BITS   = 256;
    localparam int PROD_BITS = 512;

    // Bit position of 2^255; 2^255 is congruent to 19 mod q.
    localparam int FOLD_POS  = 255;

    localparam logic [FE_BITS-1:0] Q =
        256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FOLD1 = 3'd1,
        S_FOLD2 = 3'd2,
        S_FOLD3 = 3'd3,
        S_CSUB  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/seq_mod_reduce_q_fold_19.sv
// One folding step: y = x[254:0] + 19 * x[W-1:255]. Uses 2^255 == 19 (mod q),
// so y is congruent to x. The x19 is built from shifts and adds only.
module fold_19
    import seq_mod_reduce_q_pkg::*;
#(
    parameter int W = PROD_BITS
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    localparam int HW = W - FOLD_POS;   // width of the high part
    localparam int MW = HW + 5;         // 19 * h needs 5 extra bits

    logic [HW-1:0] h;
    logic [MW-1:0] h19;

    // Split, multiply the high part by 19 as 16h + 2h + h, and add back.
    always_comb begin
        h   = x[W-1:FOLD_POS];
        h19 = {1'b0, h, 4'b0000} + {4'b0000, h, 1'b0} + {5'b00000, h};
        y   = {{(W-FOLD_POS){1'b0}}, x[FOLD_POS-1:0]}
            + {{(W-MW){1'b0}}, h19};
    end

endmodule

// File: rtl/seq_mod_reduce_q.sv
// Sequential reduction of a 512-bit product modulo q = 2^255 - 19.
// Three fold steps bring the value below 2^255 + 19 (< 2q), and one
// conditional subtraction gives the canonical residue. A new request is
// accepted every 6 cycles; start is ignored while busy.
module seq_mod_reduce_q
    import seq_mod_reduce_q_pkg::*;
#(
    parameter int B  = FE_BITS,
    parameter int B2 = PROD_BITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [B2-1:0] product,
    output logic [B-1:0]  result,
    output logic          done,
    output logic          busy
);

    state_t        state;
    state_t        state_nxt;

    // Working value. Holds the full product only between IDLE and FOLD1;
    // after the first fold it fits in 263 bits and the upper bits stay zero.
    logic [B2-1:0] x;
    logic [B2-1:0] fold_y;

    // x - q with borrow in the top bit; a borrow means x < q.
    logic [B:0]    sub;

    fold_19 #(.W(B2)) u_fold (
        .x (x),
        .y (fold_y)
    );

    // Single subtractor used by the final correction step.
    always_comb begin
        sub = {1'b0, x[B-1:0]} - {1'b0, B'(Q)};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state sequencing and status outputs.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_FOLD1;
            end
            S_FOLD1: state_nxt = S_FOLD2;
            S_FOLD2: state_nxt = S_FOLD3;
            S_FOLD3: state_nxt = S_CSUB;
            S_CSUB:  state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Working register: capture the operand on accept, fold in FOLD1..3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
        end else begin
            case (state)
                S_IDLE:  if (start) x <= product;
                S_FOLD1,
                S_FOLD2,
                S_FOLD3: x <= fold_y;
                default: x <= x;
            endcase
        end
    end

    // Result register: updated only in CSUB, held until the next CSUB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else if (state == S_CSUB) begin
            result <= sub[B] ? x[B-1:0] : sub[B-1:0];
        end
    end

endmodule

// File: tb/tb_seq_mod_reduce_q.sv
// Bench for seq_mod_reduce_q: directed corner products, randomized products
// against a plain modular-arithmetic model, reset abort and start-while-busy.
module tb_seq_mod_reduce_q;
    import seq_mod_reduce_q_pkg::*;

    logic         clk;
    logic         rst;
    logic         start;
    logic [511:0] product;
    logic [255:0] result;
    logic         done;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [255:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [255:0] last_res = '0;

    seq_mod_reduce_q dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .product (product),
        .result  (result),
        .done    (done),
        .busy    (busy)
    );

    // Clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: residue computed directly with wide modulo.
    function automatic logic [255:0] ref_mod(input logic [511:0] p);
        logic [511:0] r;
        r = p % {256'd0, Q};
        return r[255:0];
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Driver: call at posedge+#1 with the DUT idle; returns at posedge+#1
    // after the DONE cycle, so calls chain at full throughput.
    task automatic reduce(input logic [511:0] p, input logic [255:0] e);
        start   = 1'b1;
        product = p;
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 5);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy after accept", {255'd0, busy}, 256'd1);
        repeat (5) @(posedge clk);
        #1;
        check("busy back to idle", {255'd0, busy}, 256'd0);
    endtask

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                last_res = '0;
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected done: result %h with nothing pending", result);
                end else begin
                    logic [255:0] e;
                    int           ec;
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("result", result, e);
                    check("done latency", 256'(cyc), 256'(ec));
                    last_res = e;
                end
            end else begin
                check("result hold", result, last_res);
                if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done timeout: no done by cycle %0d expected %0d", cyc, exp_cyc_q[0]);
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Stimulus.
    initial begin
        logic [255:0] q_v;
        logic [511:0] p;
        q_v     = Q;
        rst     = 1'b1;
        start   = 1'b0;
        product = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset result", result, 256'd0);
        check("reset busy", {255'd0, busy}, 256'd0);
        check("reset done", {255'd0, done}, 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed corners.
        reduce(512'd0, 256'd0);
        reduce({256'd0, q_v}, 256'd0);
        reduce({256'd0, q_v - 256'd1}, q_v - 256'd1);
        p = '0;
        p[254:0] = '1;
        reduce(p, 256'd18);
        p = {256'd0, q_v - 256'd1};
        p = p << 255;
        reduce(p, q_v - 256'd19);
        p = '1;
        reduce(p, 256'd1443);

        // Reset while in FOLD2 abandons the reduction.
        start   = 1'b1;
        product = rand512();
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort result", result, 256'd0);
        check("abort busy", {255'd0, busy}, 256'd0);
        check("abort done", {255'd0, done}, 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        p = '0;
        p[255] = 1'b1;
        reduce(p, 256'd19);

        // start held high while busy with a different operand.
        start   = 1'b1;
        product = 512'd5;
        exp_q.push_back(256'd5);
        exp_cyc_q.push_back(cyc + 5);
        @(posedge clk); #1;
        product = 512'd7;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("busy after held start", {255'd0, busy}, 256'd0);

        // Randomized products: full-width, small, and near multiples of q.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0: p = rand512();
                1: p = {480'd0, 32'($urandom())};
                default: begin
                    p = {256'd0, q_v} * {480'd0, 32'($urandom_range(0, 8))};
                    p = p + {480'd0, 32'($urandom_range(0, 40))} - 512'd20;
                end
            endcase
            reduce(p, ref_mod(p));
        end

        repeat (8) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending at end: got %0d outstanding expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
